cnn_result_reader: RTL and testbench

Drains the convolution output feature map after the `control` block signals completion. It reads the output buffer RAM in raster order, which has a 1-cycle read latency. It optionally applies ReLU and streams the pixels out over a valid/ready interface with row-end and frame-end markers. It sits downstream of `control` and the output RAM, and is the consumer end of the start/done exchange that `control` runs.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/cnn_result_reader_fifo2.sv | 52 +++++
 rtl/cnn_result_reader.sv | 133 +++++++++++++
 tb/tb_cnn_result_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Constants shared by control, the convolution datapath and the result reader,
// plus the reader's state encoding and output-buffer entry layout.
package cnn_pkg;

  localparam int CNN_DATA_W = 16;
  localparam int CNN_OUT_H  = 3;
  localparam int CNN_OUT_W  = 3;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [CNN_DATA_W-1:0] data;
    logic                  row_end;
    logic                  last;
  } buf_entry_t;

endpackage

// File: rtl/cnn_result_reader_fifo2.sv
// Generic 2-deep synchronous FIFO; head entry is visible combinationally on dout_o.
// Pushing while full or popping while empty is the caller's responsibility.
module fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cnn_result_reader.sv
// Drains the output feature-map RAM in raster order after control's done pulse,
// optionally applies ReLU, and streams pixels with row-end/frame-end markers.
module cnn_result_reader
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int OUT_H  = CNN_OUT_H,
  parameter int OUT_W  = CNN_OUT_W,
  parameter int ADDR_W = 4,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_row_end,
  output logic              out_last,
  output logic              busy,
  output logic              done_dropped
);

  localparam int NPIX  = OUT_H * OUT_W;
  localparam int ENT_W = DATA_W + 2;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_W - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              inflight_q;
  logic              infl_row_end_q;
  logic              infl_last_q;
  logic              done_dropped_q, done_dropped_d;

  logic [1:0]        fifo_count;
  logic [ENT_W-1:0]  fifo_dout;
  logic [ENT_W-1:0]  push_entry;
  logic [DATA_W-1:0] relu_data;
  logic              pop;
  logic [2:0]        occupancy;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Slots already committed next cycle: stored entries plus the read in flight,
  // minus the one leaving now. Issuing only below 2 keeps the buffer from overflowing.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == RD_READ) && (occupancy < 3'd2);
  assign rd_addr   = addr_q;

  assign relu_data  = ((RELU != 0) && rd_data[DATA_W-1]) ? '0 : rd_data;
  assign push_entry = {relu_data, infl_row_end_q, infl_last_q};

  fifo2 #(
    .W (ENT_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (fifo_dout),
    .count_o (fifo_count)
  );

  assign out_data    = fifo_dout[ENT_W-1:2];
  assign out_row_end = fifo_dout[1];
  assign out_last    = fifo_dout[0];

  assign busy         = (state_q != RD_IDLE);
  assign done_dropped = done_dropped_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    col_d          = col_q;
    done_dropped_d = done_dropped_q | (done & busy);
    case (state_q)
      RD_IDLE: begin
        if (done) begin
          state_d = RD_READ;
          addr_d  = '0;
          col_d   = '0;
        end
      end
      RD_READ: begin
        if (rd_en) begin
          // Address holds on the final read so it never points past the frame.
          if (addr_q == LAST_ADDR) begin
            state_d = RD_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end
      end
      RD_DRAIN: begin
        if (pop && out_last) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RD_IDLE;
      addr_q         <= '0;
      col_q          <= '0;
      inflight_q     <= 1'b0;
      infl_row_end_q <= 1'b0;
      infl_last_q    <= 1'b0;
      done_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      col_q          <= col_d;
      inflight_q     <= rd_en;
      infl_row_end_q <= (col_q == LAST_COL);
      infl_last_q    <= (addr_q == LAST_ADDR);
      done_dropped_q <= done_dropped_d;
    end
  end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Scoreboard bench: one reader with ReLU, one without, sharing RAM contents and stream controls.
module tb_cnn_result_reader;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic reset, done, out_ready;

  logic        rd_en1, rd_en0;
  logic [3:0]  rd_addr1, rd_addr0;
  logic [15:0] rd_data1, rd_data0;
  logic        out_valid1, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic        out_row_end1, out_row_end0, out_last1, out_last0;
  logic        busy1, busy0, done_dropped1, done_dropped0;

  logic [15:0] ram [16];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  buf_entry_t  exp_q1 [$];
  logic [15:0] exp_q0 [$];
  logic [15:0] cur_raw [9];
  logic [15:0] cur_relu [9];

  logic [15:0] seq_raw  [9] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  logic [15:0] relu_raw [9] = '{16'hFFFB, 16'h0000, 16'h0007, 16'h8000, 16'h0003,
                                16'hFFFF, 16'h7FFF, 16'hFFFE, 16'h0064};
  logic [15:0] relu_exp [9] = '{16'h0000, 16'h0000, 16'h0007, 16'h0000, 16'h0003,
                                16'h0000, 16'h7FFF, 16'h0000, 16'h0064};
  logic [31:0] rdy_pat = 32'h4E3A_6D59;

  cnn_result_reader #(.DATA_W(16), .OUT_H(3), .OUT_W(3), .ADDR_W(4), .RELU(1)) dut1 (
    .clk(clk), .reset(reset), .done(done),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_row_end(out_row_end1), .out_last(out_last1),
    .busy(busy1), .done_dropped(done_dropped1)
  );

  cnn_result_reader #(.DATA_W(16), .OUT_H(3), .OUT_W(3), .ADDR_W(4), .RELU(0)) dut0 (
    .clk(clk), .reset(reset), .done(done),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_row_end(out_row_end0), .out_last(out_last0),
    .busy(busy0), .done_dropped(done_dropped0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= ram[rd_addr1];
    if (rd_en0) rd_data0 <= ram[rd_addr0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the stream rules.
  logic        stall_q = 1'b0;
  logic [17:0] stall_dat = '0;
  int          tb_cnt = 0;
  int          tb_infl = 0;
  logic        pop1;
  buf_entry_t  e1;
  logic [15:0] e0;

  always @(negedge clk) begin
    pop1 = out_valid1 && out_ready;
    if (reset) begin
      tb_cnt  = 0;
      tb_infl = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 32'(out_valid1), 32'd1);
        chk("stall_data", 32'({out_data1, out_row_end1, out_last1}), 32'(stall_dat));
      end
      chk("valid_vs_occupancy", 32'(out_valid1), 32'(tb_cnt != 0));
      if (rd_en1) chk("issue_room", 32'((tb_cnt + tb_infl - int'(pop1)) < 2), 32'd1);
      if (pop1) begin
        if (exp_q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat_relu: got %0d, expected no beat", out_data1);
        end else begin
          e1 = exp_q1.pop_front();
          chk("beat_data_relu", 32'(out_data1), 32'(e1.data));
          chk("beat_row_end", 32'(out_row_end1), 32'(e1.row_end));
          chk("beat_last", 32'(out_last1), 32'(e1.last));
        end
      end
      tb_cnt    = tb_cnt + tb_infl - int'(pop1);
      tb_infl   = int'(rd_en1);
      stall_q   = out_valid1 && !out_ready;
      stall_dat = {out_data1, out_row_end1, out_last1};

      if (out_valid0 && out_ready) begin
        if (exp_q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat_raw: got %0d, expected no beat", out_data0);
        end else begin
          e0 = exp_q0.pop_front();
          chk("beat_data_raw", 32'(out_data0), 32'(e0));
        end
      end
    end
  end

  task automatic set_frame(input logic [15:0] raw [9], input logic [15:0] rel [9]);
    for (int k = 0; k < 9; k++) begin
      ram[k]      = raw[k];
      cur_raw[k]  = raw[k];
      cur_relu[k] = rel[k];
    end
  endtask

  task automatic push_exp();
    buf_entry_t e;
    for (int k = 0; k < 9; k++) begin
      e.data    = cur_relu[k];
      e.row_end = (k == 2 || k == 5 || k == 8);
      e.last    = (k == 8);
      exp_q1.push_back(e);
      exp_q0.push_back(cur_raw[k]);
    end
  endtask

  // Drives done for one cycle; returns just after the following rising edge.
  task automatic pulse_done();
    @(posedge clk); #1;
    done = 1'b1;
    push_exp();
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy1 && t < 300);
    chk("frame_completes", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset();
    chk("rst_rd_en", 32'(rd_en1), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr1), 32'd0);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_out_data", 32'(out_data1), 32'd0);
    chk("rst_out_row_end", 32'(out_row_end1), 32'd0);
    chk("rst_out_last", 32'(out_last1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done_dropped", 32'(done_dropped1), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset();

    // Nominal frame with exact start latency, throughput and busy timing.
    set_frame(seq_raw, seq_raw);
    pulse_done();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("nom_valid", 32'(out_valid1), 32'(k >= 3 && k <= 11));
      chk("nom_busy", 32'(busy1), 32'(k <= 11));
      chk("nom_rd_en", 32'(rd_en1), 32'(k <= 9));
      if (k == 1) chk("nom_first_addr", 32'(rd_addr1), 32'd0);
    end
    wait_idle();

    // ReLU on negative, zero, positive and extreme values.
    set_frame(relu_raw, relu_exp);
    pulse_done();
    wait_idle();

    // Backpressure with a fixed irregular ready pattern.
    set_frame(seq_raw, seq_raw);
    pulse_done();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy1) break;
      out_ready = rdy_pat[i % 32];
    end
    out_ready = 1'b1;
    chk("bp_frame_completes", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);

    // done while busy: mid-frame, on the last handshake, then just after busy falls.
    chk("dd_before", 32'(done_dropped1), 32'd0);
    set_frame(seq_raw, seq_raw);
    @(posedge clk); #1;
    done = 1'b1;
    push_exp();
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      done = (t == 5 || t == 11 || t == 12);
      if (t == 12) push_exp();
      @(negedge clk);
      if (t == 11) chk("dd_last_beat", 32'({out_valid1, out_last1, busy1}), 32'b111);
      if (t == 12) chk("dd_busy_gap", 32'(busy1), 32'd0);
    end
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    chk("dd_restart_busy", 32'(busy1), 32'd1);
    chk("dd_sticky", 32'(done_dropped1), 32'd1);
    wait_idle();
    chk("dd_still_set", 32'(done_dropped1), 32'd1);

    // Reset in the middle of a frame, after four beats, while a read is issued.
    set_frame(seq_raw, seq_raw);
    pulse_done();
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_en", 32'(rd_en1), 32'd1);
    chk("mid_rst_beats_left", 32'(exp_q1.size()), 32'd5);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q1.delete();
    exp_q0.delete();
    @(negedge clk);
    check_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_flushed", 32'(out_valid1), 32'd0);
    end
    pulse_done();
    wait_idle();

    chk("sb_relu_empty", 32'(exp_q1.size()), 32'd0);
    chk("sb_raw_empty", 32'(exp_q0.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
